// File: rtl/mac_core.sv
// Two-stage pipelined signed multiply-accumulate core.
// Every flop sits on a single scan chain: a_q, then b_q, acc_in_q, acc_out_q.
module mac_core #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scan_en,
  input  logic                 scanin,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [ACC_WIDTH-1:0] acc_in,
  output logic                 scanout,
  output logic [ACC_WIDTH-1:0] acc_out
);

  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [ACC_WIDTH-1:0] acc_in_q, acc_in_d;
  logic [ACC_WIDTH-1:0] acc_out_q, acc_out_d;

  logic signed [2*WIDTH-1:0]   a_ext, b_ext, prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;

  // Operands are widened before multiplying so the low 2*WIDTH bits hold the exact signed product.
  always_comb begin
    a_ext    = (2*WIDTH)'($signed(a_q));
    b_ext    = (2*WIDTH)'($signed(b_q));
    prod     = a_ext * b_ext;
    prod_ext = ACC_WIDTH'(prod);

    if (scan_en) begin
      a_d       = {a_q[WIDTH-2:0], scanin};
      b_d       = {b_q[WIDTH-2:0], a_q[WIDTH-1]};
      acc_in_d  = {acc_in_q[ACC_WIDTH-2:0], b_q[WIDTH-1]};
      acc_out_d = {acc_out_q[ACC_WIDTH-2:0], acc_in_q[ACC_WIDTH-1]};
    end else begin
      a_d       = a;
      b_d       = b;
      acc_in_d  = acc_in;
      acc_out_d = acc_in_q + prod_ext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_in_q  <= '0;
      acc_out_q <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      acc_in_q  <= acc_in_d;
      acc_out_q <= acc_out_d;
    end
  end

  assign acc_out = acc_out_q;
  assign scanout = acc_out_q[ACC_WIDTH-1];

endmodule

// File: doc/mac_core.md
# mac_core

Two-stage pipelined signed multiply-accumulate core with a full-register scan chain. It sits directly inside the MAC pad ring. It consumes the pad-side core signals `a_I`, `b_I`, `acc_in_I`, `scan_en_I`, `scanin_I`, `clk_I` and `rst_I`, and drives `acc_out_I` and `scanout_I`. All state is held in one scan chain so that shift-in, capture and shift-out can exercise the core through the pads.

## Interface
- `WIDTH`, default 16: operand width for `a` and `b`.
- `ACC_WIDTH`, default 32: accumulator width. Must satisfy `ACC_WIDTH >= 2*WIDTH`. The pad ring uses the defaults.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `scan_en`, input, 1: 1 = shift mode, 0 = functional mode.
- `scanin`, input, 1: scan chain serial input.
- `a`, input, WIDTH: multiplicand, two's complement.
- `b`, input, WIDTH: multiplier, two's complement.
- `acc_in`, input, ACC_WIDTH: addend, two's complement.
- `scanout`, output, 1: scan chain serial output.
- `acc_out`, output, ACC_WIDTH: registered result.

## Operation
- Registers:
  - stage 1: `a_r`, `b_r`, `acc_in_r`
  - stage 2: `acc_out_r`
  - `acc_out` = `acc_out_r` directly, with no combinational path from the inputs.
- Functional mode (`scan_en`=0), on every rising edge:
  - `a_r`<=`a`, `b_r`<=`b`, `acc_in_r`<=`acc_in`
  - `acc_out_r` <= `acc_in_r` + sign_extend(`a_r`*`b_r`, ACC_WIDTH), truncated to ACC_WIDTH bits.
- Arithmetic rules:
  - The product is a signed WIDTH×WIDTH multiply giving 2*WIDTH bits, sign-extended to ACC_WIDTH.
  - The sum wraps modulo 2^ACC_WIDTH. There is no saturation and no overflow flag.
- Scan chain:
  - Length N = 2*WIDTH + 2*ACC_WIDTH (96 at defaults).
  - Chain position c[k] maps as follows (bit 0 first within each field):
    - k in 0..WIDTH-1 = `a_r`
    - next WIDTH positions = `b_r`
    - next ACC_WIDTH positions = `acc_in_r`
    - last ACC_WIDTH positions = `acc_out_r`
- Shift mode (`scan_en`=1), on every rising edge:
  - c[0]<=`scanin`, and c[k]<=c[k-1] for k=1..N-1.
  - The functional D paths are ignored.
  - `a`, `b` and `acc_in` are don't-care.
- `scanout` = c[N-1] = `acc_out_r[ACC_WIDTH-1]`, taken combinationally from the flop Q with no extra stage.
- Mode switching:
  - `scan_en` is sampled on each edge. The mode of an edge depends only on `scan_en` at that edge.
  - Changing `scan_en` between edges causes no extra transition.
  - Capture after a shift-in is a single edge with `scan_en`=0. Stage 2 computes from the scanned-in stage-1 values.
- Reset (`rst`=0):
  - All N flops clear to 0 immediately, without waiting for a clock edge.
  - During reset `acc_out`=0 and `scanout`=0.
  - Reset overrides both modes.
  - Release is synchronous to the design's use, so the first edge with `rst`=1 performs a normal functional or shift update.

## Timing
- Latency is 2 edges. Inputs presented before edge E appear on `acc_out` after edge E+1.
- Throughput is one new operation per cycle. Back-to-back operations are independent, with no internal feedback.
- After reset release, `acc_out` remains 0 until the second functional edge. The first functional edge computes from the zeroed stage-1 registers, giving 0.
- Reset asserted mid-pipeline discards both in-flight operations. `acc_out` returns to 0 asynchronously.
- Full scan load needs N edges with `scan_en`=1. Full unload needs N edges, and the first bit out (c[N-1]) is visible before the first shift edge.
- The critical path is the multiply-add between stage-1 and stage-2 registers. No other combinational logic sits between registers.

## Test plan
- **Reset values:**
  - Stimulus: hold `rst`=0, toggle `clk` with random `a`, `b`, `acc_in`.
  - Required response: `acc_out`=0x00000000 and `scanout`=0 throughout.
  - Stimulus: assert `rst`=0 asynchronously mid-cycle while `acc_out` is nonzero.
  - Required response: `acc_out` drops to 0 before the next edge.
- **Signed MAC and latency:**
  - Stimulus: `a`=3, `b`=0xFFFE (-2), `acc_in`=10 at edge E.
  - Required response: `acc_out`=0x00000004 after E+1, and not after E.
  - Stimulus: `a`=0x8000, `b`=0x8000, `acc_in`=0.
  - Required response: `acc_out`=0x40000000.
- **Wrap-around:**
  - Stimulus: `a`=0x7FFF, `b`=0x7FFF, `acc_in`=0x7FFFFFFF.
  - Required response: `acc_out`=0xBFFF0000.
  - Stimulus: `a`=0xFFFF, `b`=1, `acc_in`=0x00000000.
  - Required response: `acc_out`=0xFFFFFFFF.
- **Pipelining:**
  - Stimulus: back-to-back triples (1,1,0), (2,3,1), (-1,-1,5) on consecutive edges.
  - Required response: `acc_out` = 1, 7, 6 on consecutive cycles.
- **Scan shift-through:**
  - Stimulus: after reset, `scan_en`=1, shift in the 96-bit pattern 0xA5A5…, then shift 96 more bits.
  - Required response: `scanout` reproduces the pattern delayed by 96 edges.
  - Check: the first 96 `scanout` values are all 0 (reset contents).
- **Scan capture:**
  - Stimulus: shift in `a_r`=5, `b_r`=6, `acc_in_r`=7, `acc_out_r`=0. Then one edge with `scan_en`=0, then `scan_en`=1.
  - Required response: the 32 `scanout` bits (MSB first) are 0x00000025.
